// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS main control: steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB,
// with a memory-ready handshake, a wait timeout, an illegal-opcode trap and a retire pulse.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT  = 15,
  parameter bit SUPPORT_IMM  = 1'b1,
  parameter bit SUPPORT_JUMP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opCode,
  input  logic       zero,
  input  logic       memReady,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] aluOp,
  output logic [1:0] pcSource,
  output logic       pcWrite,
  output logic [3:0] state,
  output logic       instrDone,
  output logic       illegalOp,
  output logic       memTimeout
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       illegal_q, illegal_d;
  logic       timeout_q, timeout_d;
  logic       mem_wait;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= 8'd0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    mem_wait  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_wait = 1'b1;
        if (memReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opCode)
          OP_RTYPE:       state_d = S_EXEC;
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = SUPPORT_JUMP ? S_JUMP : S_TRAP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:
                          state_d = SUPPORT_IMM ? S_IEXEC : S_TRAP;
          default:        state_d = S_TRAP;
        endcase
        if (state_d == S_TRAP) illegal_d = 1'b1;
      end
      S_MEMADR: state_d = (opCode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        mem_wait = 1'b1;
        if (memReady) state_d = S_MEMWB;
      end
      S_MEMWB: state_d = S_FETCH;
      S_MEMWR: begin
        mem_wait = 1'b1;
        if (memReady) state_d = S_FETCH;
      end
      S_EXEC:   state_d = S_RTWB;
      S_RTWB:   state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase

    // A ready on the last allowed wait cycle still completes; only a miss there traps.
    if (mem_wait && !memReady && (wait_cnt_q == WAIT_LAST)) begin
      state_d   = S_TRAP;
      timeout_d = 1'b1;
    end

    if (state_d != state_q)
      wait_cnt_d = 8'd0;
    else if (mem_wait && !memReady)
      wait_cnt_d = wait_cnt_q + 8'd1;
    else
      wait_cnt_d = wait_cnt_q;
  end

  always_comb begin
    iorD      = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    regDst    = 1'b0;
    memToReg  = 1'b0;
    regWrite  = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = 2'b00;
    aluOp     = 3'b000;
    pcSource  = 2'b00;
    pcWrite   = 1'b0;
    instrDone = 1'b0;
    // Holding reset masks every enable so an interrupted instruction leaves no side effects.
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          memRead = 1'b1;
          aluSrcB = 2'b01;
          irWrite = memReady;
          pcWrite = memReady;
        end
        S_DECODE: aluSrcB = 2'b11;
        S_MEMADR: begin
          aluSrcA = 1'b1;
          aluSrcB = 2'b10;
        end
        S_MEMRD: begin
          memRead = 1'b1;
          iorD    = 1'b1;
        end
        S_MEMWB: begin
          memToReg  = 1'b1;
          regWrite  = 1'b1;
          instrDone = 1'b1;
        end
        S_MEMWR: begin
          memWrite  = 1'b1;
          iorD      = 1'b1;
          instrDone = memReady;
        end
        S_EXEC: begin
          aluSrcA = 1'b1;
          aluOp   = 3'b010;
        end
        S_RTWB: begin
          regDst    = 1'b1;
          regWrite  = 1'b1;
          instrDone = 1'b1;
        end
        S_BRANCH: begin
          aluSrcA   = 1'b1;
          aluOp     = 3'b001;
          pcSource  = 2'b01;
          pcWrite   = (opCode == OP_BEQ) ? zero : ~zero;
          instrDone = 1'b1;
        end
        S_JUMP: begin
          pcSource  = 2'b10;
          pcWrite   = 1'b1;
          instrDone = 1'b1;
        end
        S_IEXEC: begin
          aluSrcA = 1'b1;
          aluSrcB = 2'b10;
          case (opCode)
            OP_ANDI: aluOp = 3'b011;
            OP_ORI:  aluOp = 3'b100;
            OP_SLTI: aluOp = 3'b101;
            default: aluOp = 3'b000;
          endcase
        end
        S_IWB: begin
          regWrite  = 1'b1;
          instrDone = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state      = state_q;
  assign illegalOp  = illegal_q;
  assign memTimeout = timeout_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: two instances (full feature set, and no imm/jump with a short
// timeout) share stimulus; an instruction-path model is compared every cycle, plus literal checks.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic [1:0] pcSource;
    logic       pcWrite;
    logic       instrDone;
  } ctrl_t;

  localparam int TO0 = 15;
  localparam int TO1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, zero, memReady;
  logic [5:0] opCode;

  logic [1:0]      iorD, memRead, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA;
  logic [1:0]      pcWrite, instrDone, illegalOp, memTimeout;
  logic [1:0][1:0] aluSrcB, pcSource;
  logic [1:0][2:0] aluOp;
  logic [1:0][3:0] st;

  multicycle_control_fsm #(.MEM_TIMEOUT(TO0), .SUPPORT_IMM(1'b1), .SUPPORT_JUMP(1'b1)) u0 (
    .clk(clk), .reset(reset), .opCode(opCode), .zero(zero), .memReady(memReady),
    .iorD(iorD[0]), .memRead(memRead[0]), .memWrite(memWrite[0]), .irWrite(irWrite[0]),
    .regDst(regDst[0]), .memToReg(memToReg[0]), .regWrite(regWrite[0]), .aluSrcA(aluSrcA[0]),
    .aluSrcB(aluSrcB[0]), .aluOp(aluOp[0]), .pcSource(pcSource[0]), .pcWrite(pcWrite[0]),
    .state(st[0]), .instrDone(instrDone[0]), .illegalOp(illegalOp[0]), .memTimeout(memTimeout[0])
  );

  multicycle_control_fsm #(.MEM_TIMEOUT(TO1), .SUPPORT_IMM(1'b0), .SUPPORT_JUMP(1'b0)) u1 (
    .clk(clk), .reset(reset), .opCode(opCode), .zero(zero), .memReady(memReady),
    .iorD(iorD[1]), .memRead(memRead[1]), .memWrite(memWrite[1]), .irWrite(irWrite[1]),
    .regDst(regDst[1]), .memToReg(memToReg[1]), .regWrite(regWrite[1]), .aluSrcA(aluSrcA[1]),
    .aluSrcB(aluSrcB[1]), .aluOp(aluOp[1]), .pcSource(pcSource[1]), .pcWrite(pcWrite[1]),
    .state(st[1]), .instrDone(instrDone[1]), .illegalOp(illegalOp[1]), .memTimeout(memTimeout[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit run     = 1'b0;

  // Model: current state, remaining state path of the decoded instruction, wait count, flags.
  int   m_st   [2] = '{0, 0};
  int   m_wait [2] = '{0, 0};
  logic m_ill  [2] = '{1'b0, 1'b0};
  logic m_to   [2] = '{1'b0, 1'b0};
  int   m_path [2][4];
  int   m_plen [2] = '{0, 0};
  int   m_pidx [2] = '{0, 0};

  logic [5:0] imm_op  [4] = '{6'd8, 6'd12, 6'd13, 6'd10};
  logic [2:0] imm_alu [4] = '{3'b000, 3'b011, 3'b100, 3'b101};

  function automatic int to_of(input int i);
    return (i == 0) ? TO0 : TO1;
  endfunction

  task automatic set_path(input int i, input int n, input int a, input int b, input int c);
    m_path[i][0] = a;
    m_path[i][1] = b;
    m_path[i][2] = c;
    m_plen[i] = n;
    m_pidx[i] = 0;
  endtask

  task automatic plan(input int i);
    bit imm_ok, j_ok;
    imm_ok = (i == 0);
    j_ok   = (i == 0);
    case (opCode)
      6'd0:           set_path(i, 2, 6, 7, 0);
      6'd35:          set_path(i, 3, 2, 3, 4);
      6'd43:          set_path(i, 2, 2, 5, 0);
      6'd4, 6'd5:     set_path(i, 1, 8, 0, 0);
      6'd2:           if (j_ok) set_path(i, 1, 9, 0, 0); else set_path(i, 1, 12, 0, 0);
      6'd8, 6'd10, 6'd12, 6'd13:
                      if (imm_ok) set_path(i, 2, 10, 11, 0); else set_path(i, 1, 12, 0, 0);
      default:        set_path(i, 1, 12, 0, 0);
    endcase
    if (m_path[i][0] == 12) m_ill[i] = 1'b1;
  endtask

  task automatic model_step(input int i);
    if (reset) begin
      m_st[i] = 0; m_wait[i] = 0; m_ill[i] = 1'b0; m_to[i] = 1'b0;
      m_plen[i] = 0; m_pidx[i] = 0;
      return;
    end
    if (m_st[i] == 12) return;
    if ((m_st[i] == 0 || m_st[i] == 3 || m_st[i] == 5) && !memReady) begin
      m_wait[i]++;
      if (m_wait[i] >= to_of(i)) begin
        m_st[i] = 12;
        m_to[i] = 1'b1;
        m_wait[i] = 0;
      end
      return;
    end
    m_wait[i] = 0;
    if (m_st[i] == 1) plan(i);
    if (m_st[i] == 0) m_st[i] = 1;
    else if (m_pidx[i] < m_plen[i]) begin
      m_st[i] = m_path[i][m_pidx[i]];
      m_pidx[i]++;
    end else m_st[i] = 0;
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  function automatic ctrl_t exp_ctrl(input int s, input logic [5:0] op, input logic z,
                                     input logic rdy, input logic rst);
    ctrl_t c;
    c = '0;
    if (rst) return c;
    case (s)
      0:  begin c.memRead = 1; c.aluSrcB = 2'b01; c.irWrite = rdy; c.pcWrite = rdy; end
      1:  c.aluSrcB = 2'b11;
      2:  begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
      3:  begin c.memRead = 1; c.iorD = 1; end
      4:  begin c.memToReg = 1; c.regWrite = 1; c.instrDone = 1; end
      5:  begin c.memWrite = 1; c.iorD = 1; c.instrDone = rdy; end
      6:  begin c.aluSrcA = 1; c.aluOp = 3'b010; end
      7:  begin c.regDst = 1; c.regWrite = 1; c.instrDone = 1; end
      8:  begin
            c.aluSrcA = 1; c.aluOp = 3'b001; c.pcSource = 2'b01; c.instrDone = 1;
            c.pcWrite = (op == 6'd4) ? z : ~z;
          end
      9:  begin c.pcSource = 2'b10; c.pcWrite = 1; c.instrDone = 1; end
      10: begin
            c.aluSrcA = 1; c.aluSrcB = 2'b10;
            c.aluOp = (op == 6'd12) ? 3'b011 : (op == 6'd13) ? 3'b100 :
                      (op == 6'd10) ? 3'b101 : 3'b000;
          end
      11: begin c.regWrite = 1; c.instrDone = 1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctrl_t act(input int i);
    ctrl_t c;
    c = {iorD[i], memRead[i], memWrite[i], irWrite[i], regDst[i], memToReg[i], regWrite[i],
         aluSrcA[i], aluSrcB[i], aluOp[i], pcSource[i], pcWrite[i], instrDone[i]};
    return c;
  endfunction

  always @(negedge clk) begin
    ctrl_t e, a;
    if (run) begin
      for (int i = 0; i < 2; i++) begin
        e = exp_ctrl(m_st[i], opCode, zero, memReady, reset);
        a = act(i);
        n_tests++;
        if (a !== e || st[i] !== 4'(m_st[i]) || illegalOp[i] !== m_ill[i] ||
            memTimeout[i] !== m_to[i]) begin
          n_fail++;
          $display("FAIL cycle u%0d t=%0t: got ctrl=%h state=%0d ill=%b to=%b, want ctrl=%h state=%0d ill=%b to=%b",
                   i, $time, a, st[i], illegalOp[i], memTimeout[i], e, m_st[i], m_ill[i], m_to[i]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0h, want %0h", nm, $time, a, e);
    end
  endtask

  task automatic drive(input logic r, input logic [5:0] o, input logic z, input logic m);
    reset = r; opCode = o; zero = z; memReady = m;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs n cycles; nibble k of e0/e1 is the required state of u0/u1 in cycle k, bit k of rdy
  // is memReady in cycle k. Returns u0's control word at cycle 'probe' and its instrDone count.
  task automatic seq(input string nm, input logic [5:0] op, input logic z, input int n,
                     input logic [15:0] rdy, input logic [63:0] e0, input logic [63:0] e1,
                     input int probe, output ctrl_t pc, output int dones);
    dones = 0;
    pc = '0;
    for (int k = 0; k < n; k++) begin
      drive(1'b0, op, z, rdy[k]);
      chk({nm, "_st0"}, st[0], e0[4*k +: 4]);
      chk({nm, "_st1"}, st[1], e1[4*k +: 4]);
      if (k == probe) pc = act(0);
      if (instrDone[0] === 1'b1) dones++;
      tick();
    end
  endtask

  task automatic do_reset;
    drive(1'b1, 6'd0, 1'b0, 1'b1);
    tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    ctrl_t pc;
    int    d;
    reset = 1'b1; opCode = 6'd0; zero = 1'b0; memReady = 1'b1;
    tick();
    run = 1'b1;

    drive(1'b1, 6'd0, 1'b0, 1'b1);
    chk("rst_ctrl_zero", act(0), 0);
    tick();
    drive(1'b0, 6'd0, 1'b0, 1'b1);
    chk("rst_state", st[0], 0);
    chk("rst_ill", illegalOp[0], 0);
    chk("rst_to", memTimeout[0], 0);

    seq("rtype", 6'd0, 1'b0, 4, 16'hFFFF, 64'h7610, 64'h7610, 3, pc, d);
    chk("rtype_regwrite", pc.regWrite, 1);
    chk("rtype_regdst", pc.regDst, 1);
    chk("rtype_done", d, 1);

    seq("lw", 6'd35, 1'b0, 8, 16'hFFC7, 64'h4333_3210, 64'h4333_3210, 7, pc, d);
    chk("lw_memtoreg", pc.memToReg, 1);
    chk("lw_done", d, 1);
    drive(1'b0, 6'd0, 1'b0, 1'b1);
    chk("lw_u1_ready_on_last_wait", memTimeout[1], 0);

    seq("sw", 6'd43, 1'b0, 4, 16'hFFFF, 64'h5210, 64'h5210, 3, pc, d);
    chk("sw_memwrite", pc.memWrite, 1);
    chk("sw_done", d, 1);

    seq("beq_z1", 6'd4, 1'b1, 3, 16'hFFFF, 64'h810, 64'h810, 2, pc, d);
    chk("beq_z1_pcwrite", pc.pcWrite, 1);
    chk("beq_pcsource", pc.pcSource, 2'b01);
    seq("bne_z1", 6'd5, 1'b1, 3, 16'hFFFF, 64'h810, 64'h810, 2, pc, d);
    chk("bne_z1_pcwrite", pc.pcWrite, 0);
    seq("bne_z0", 6'd5, 1'b0, 3, 16'hFFFF, 64'h810, 64'h810, 2, pc, d);
    chk("bne_z0_pcwrite", pc.pcWrite, 1);
    seq("beq_z0", 6'd4, 1'b0, 3, 16'hFFFF, 64'h810, 64'h810, 2, pc, d);
    chk("beq_z0_pcwrite", pc.pcWrite, 0);
    chk("branch_back_to_fetch", st[0], 0);

    seq("jump", 6'd2, 1'b0, 3, 16'hFFFF, 64'h910, 64'hC10, 2, pc, d);
    chk("jump_pcwrite", pc.pcWrite, 1);
    chk("jump_pcsource", pc.pcSource, 2'b10);
    drive(1'b0, 6'd0, 1'b0, 1'b1);
    chk("jump_u0_legal", illegalOp[0], 0);
    chk("jump_u1_illegal", illegalOp[1], 1);

    drive(1'b1, 6'd0, 1'b0, 1'b1);
    chk("rst_masks_irwrite", irWrite[0], 0);
    tick();
    drive(1'b0, 6'd0, 1'b0, 1'b1);
    chk("rst_clears_ill", illegalOp[1], 0);

    for (int k = 0; k < 4; k++) begin
      seq("imm", imm_op[k], 1'b0, 4, 16'hFFFF, 64'hBA10, 64'hCC10, 2, pc, d);
      chk("imm_aluop", pc.aluOp, imm_alu[k]);
      chk("imm_alusrcb", pc.aluSrcB, 2'b10);
      drive(1'b0, 6'd0, 1'b0, 1'b1);
      chk("imm_u1_illegal", illegalOp[1], 1);
      do_reset();
    end

    seq("illegal", 6'd63, 1'b0, 2, 16'hFFFF, 64'h10, 64'h10, 0, pc, d);
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 6'd63, 1'b1, 1'b1);
      chk("trap_ctrl", act(0), 0);
      chk("trap_state", st[0], 12);
      chk("trap_ill", illegalOp[0], 1);
      tick();
    end
    do_reset();
    drive(1'b0, 6'd0, 1'b0, 1'b1);
    chk("trap_rst_state", st[0], 0);
    chk("trap_rst_ill", illegalOp[0], 0);

    for (int k = 0; k < TO0; k++) begin
      drive(1'b0, 6'd0, 1'b0, 1'b0);
      chk("tmo_wait_state", st[0], 0);
      chk("tmo_irwrite", irWrite[0], 0);
      chk("tmo_flag_low", memTimeout[0], 0);
      tick();
    end
    drive(1'b0, 6'd0, 1'b0, 1'b0);
    chk("tmo_state", st[0], 12);
    chk("tmo_flag", memTimeout[0], 1);
    chk("tmo_u1_flag", memTimeout[1], 1);
    do_reset();

    seq("rst_mid_r", 6'd0, 1'b0, 3, 16'hFFFF, 64'h610, 64'h610, 0, pc, d);
    drive(1'b1, 6'd0, 1'b0, 1'b1);
    chk("rst_mid_rtwb_state", st[0], 7);
    chk("rst_mid_regwrite", regWrite[0], 0);
    chk("rst_mid_done", instrDone[0], 0);
    tick();
    seq("rst_mid_sw", 6'd43, 1'b0, 3, 16'hFFFF, 64'h210, 64'h210, 0, pc, d);
    drive(1'b1, 6'd43, 1'b0, 1'b1);
    chk("rst_mid_memwr_state", st[0], 5);
    chk("rst_mid_memwrite", memWrite[0], 0);
    tick();
    drive(1'b0, 6'd0, 1'b0, 1'b1);
    chk("rst_mid_fetch", st[0], 0);
    tick();

    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
